// File: rtl/point_cmd_pkg.sv
// point_cmd_pkg: ASCII constants, state encoding and defaults shared by the point command decoder.
package point_cmd_pkg;
    localparam logic [7:0] CH_HASH = 8'h23;
    localparam logic [7:0] CH_DASH = 8'h2D;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_ZERO = 8'h30;
    localparam logic [7:0] CH_NINE = 8'h39;
    localparam int unsigned DEFAULT_MAX_NODE = 29;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SP_DIG = 2'd1,
        EP_DIG = 2'd2,
        HOLD = 2'd3
    } state_t;
endpackage

// File: rtl/point_cmd_decoder_if.sv
// point_cmd_decoder_if: UART byte stream in, decoded points and status out.
interface point_cmd_decoder_if;
    logic [7:0] rx_data;
    logic rx_valid;
    logic [7:0] SP;
    logic [7:0] EP;
    logic cpu_reset;
    logic frame_err;
    logic busy;
    modport master (output rx_data, rx_valid, input SP, EP, cpu_reset, frame_err, busy);
    modport slave (input rx_data, rx_valid, output SP, EP, cpu_reset, frame_err, busy);
endinterface

// File: rtl/ascii_digit_acc.sv
// ascii_digit_acc: accumulates up to two ASCII decimal digits into a 7-bit value.
module ascii_digit_acc
    import point_cmd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       strobe,
    input  logic [7:0] data,
    output logic       is_digit,
    output logic [6:0] acc,
    output logic [1:0] count,
    output logic       overflow
);
    assign is_digit = data >= CH_ZERO && data <= CH_NINE;
    assign overflow = is_digit && count == 2'd2;
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            acc <= '0;
            count <= '0;
        end else if (strobe && is_digit && !overflow) begin
            acc <= acc * 7'd10 + {3'b0, data[3:0]};
            count <= count + 2'd1;
        end
    end
endmodule

// File: rtl/point_cmd_decoder.sv
// point_cmd_decoder: parses "#SP-EP\n" UART frames into SP/EP node numbers and a cpu_reset window.
// Define CMD_TIMEOUT_EN to abort a partial frame after TIMEOUT_CYCLES idle cycles.
module point_cmd_decoder
    import point_cmd_pkg::*;
#(
    parameter int unsigned MAX_NODE = DEFAULT_MAX_NODE,
    parameter int unsigned HOLD_CYCLES = 4
`ifdef CMD_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYCLES = 50000
`endif
)(
    input logic adc_sck,
    input logic reset,
    point_cmd_decoder_if.slave bus
);
    state_t state;
    logic [6:0] sp_stage;
    logic [7:0] sp;
    logic [7:0] ep;
    logic cpu_reset;
    logic frame_err;
    logic busy;
    logic [31:0] hold_cnt;
    logic is_digit;
    logic overflow;
    logic [6:0] acc;
    logic [1:0] count;
    logic in_dig;
    logic take_digit;
    logic dash_ok;
    logic accept;
    logic timeout;
    logic err;
    logic resync;

    assign in_dig = state == SP_DIG || state == EP_DIG;
    assign take_digit = in_dig && bus.rx_valid && is_digit && !overflow;
    assign dash_ok = state == SP_DIG && bus.rx_valid && bus.rx_data == CH_DASH && count != 2'd0;
    assign accept = state == EP_DIG && bus.rx_valid && bus.rx_data == CH_LF && count != 2'd0
                    && 32'(sp_stage) <= MAX_NODE && 32'(acc) <= MAX_NODE;
    assign err = timeout || (in_dig && bus.rx_valid && !take_digit && !dash_ok && !accept);
    assign resync = bus.rx_valid && bus.rx_data == CH_HASH;

    // Accumulator is held clear outside the digit states and whenever a byte ends a number.
    ascii_digit_acc u_acc (
        .clk(adc_sck),
        .rst(reset),
        .clear(!in_dig || (bus.rx_valid && !take_digit)),
        .strobe(take_digit),
        .data(bus.rx_data),
        .is_digit(is_digit),
        .acc(acc),
        .count(count),
        .overflow(overflow)
    );

`ifdef CMD_TIMEOUT_EN
    logic [31:0] gap;
    assign timeout = in_dig && !bus.rx_valid && gap == TIMEOUT_CYCLES - 1;
    always_ff @(posedge adc_sck) begin
        if (reset || !in_dig || bus.rx_valid) gap <= '0;
        else gap <= gap + 32'd1;
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge adc_sck) begin
        if (reset) begin
            state <= IDLE;
            sp_stage <= '0;
            sp <= '0;
            ep <= '0;
            cpu_reset <= 1'b0;
            frame_err <= 1'b0;
            busy <= 1'b0;
            hold_cnt <= '0;
        end else begin
            frame_err <= err;
            if (err) begin
                state <= resync ? SP_DIG : IDLE;
                busy <= resync;
            end else if (state == IDLE && resync) begin
                state <= SP_DIG;
                busy <= 1'b1;
            end else if (dash_ok) begin
                sp_stage <= acc;
                state <= EP_DIG;
            end else if (accept) begin
                sp <= {1'b0, sp_stage};
                ep <= {1'b0, acc};
                cpu_reset <= 1'b1;
                hold_cnt <= '0;
                state <= HOLD;
            end else if (state == HOLD) begin
                hold_cnt <= hold_cnt + 32'd1;
                if (hold_cnt == HOLD_CYCLES - 1) begin
                    cpu_reset <= 1'b0;
                    busy <= 1'b0;
                    state <= IDLE;
                end
            end
        end
    end

    assign bus.SP = sp;
    assign bus.EP = ep;
    assign bus.cpu_reset = cpu_reset;
    assign bus.frame_err = frame_err;
    assign bus.busy = busy;
endmodule

// File: tb/tb_point_cmd_decoder.sv
// tb_point_cmd_decoder: directed byte-by-byte vectors with hand-computed expected outputs.
module tb_point_cmd_decoder;
    logic adc_sck = 1'b0;
    logic reset = 1'b1;
    int tests = 0;
    int fails = 0;

    point_cmd_decoder_if bus();

`ifdef CMD_TIMEOUT_EN
    point_cmd_decoder #(.TIMEOUT_CYCLES(20)) dut (.adc_sck(adc_sck), .reset(reset), .bus(bus.slave));
`else
    point_cmd_decoder dut (.adc_sck(adc_sck), .reset(reset), .bus(bus.slave));
`endif

    always #5 adc_sck = ~adc_sck;

    typedef struct {
        logic [7:0] data;
        logic valid;
        logic [18:0] exp;
        string tag;
    } vec_t;
    vec_t vq[$];

    function automatic logic [18:0] e(logic [7:0] sp, logic [7:0] ep, logic cr, logic fe, logic b);
        return {sp, ep, cr, fe, b};
    endfunction

    task automatic check(string n, logic [18:0] exp);
        logic [18:0] act;
        act = {bus.SP, bus.EP, bus.cpu_reset, bus.frame_err, bus.busy};
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got SP=%0d EP=%0d cpu_reset=%b frame_err=%b busy=%b, want SP=%0d EP=%0d cpu_reset=%b frame_err=%b busy=%b",
                     n, act[18:11], act[10:3], act[2], act[1], act[0], exp[18:11], exp[10:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic step(logic [7:0] d, logic v);
        @(negedge adc_sck);
        bus.rx_data = d;
        bus.rx_valid = v;
        @(posedge adc_sck);
        #1;
    endtask

    task automatic send(string s);
        for (int i = 0; i < s.len(); i++) step(s[i], 1'b1);
    endtask

    task automatic add(string tag, logic [7:0] d, logic v, logic [18:0] exp);
        vq.push_back('{d, v, exp, tag});
    endtask

    task automatic add_body(string tag, string s, logic [7:0] sp, logic [7:0] ep);
        for (int i = 0; i < s.len(); i++) add(tag, s[i], 1'b1, e(sp, ep, 0, 0, 1));
    endtask

    task automatic add_window(string tag, logic [7:0] sp, logic [7:0] ep);
        for (int i = 0; i < 3; i++) add(tag, 8'h00, 1'b0, e(sp, ep, 1, 0, 1));
        add(tag, 8'h00, 1'b0, e(sp, ep, 0, 0, 0));
    endtask

    initial begin
        bus.rx_data = 8'h00;
        bus.rx_valid = 1'b0;
        add("ignore", "A", 1'b1, e(0, 0, 0, 0, 0));
        add_body("ok_3_17", "#3-17", 0, 0);
        add("ok_3_17", 8'h0A, 1'b1, e(3, 17, 1, 0, 1));
        add_window("ok_3_17", 3, 17);
        add_body("range_sp", "#31-2", 3, 17);
        add("range_sp", 8'h0A, 1'b1, e(3, 17, 0, 1, 0));
        add("range_sp", 8'h00, 1'b0, e(3, 17, 0, 0, 0));
        add_body("third_dig", "#12", 3, 17);
        add("third_dig", "3", 1'b1, e(3, 17, 0, 1, 0));
        add("third_dig", "-", 1'b1, e(3, 17, 0, 0, 0));
        add("third_dig", "4", 1'b1, e(3, 17, 0, 0, 0));
        add("third_dig", 8'h0A, 1'b1, e(3, 17, 0, 0, 0));
        add_body("resync", "#5", 3, 17);
        add("resync", "#", 1'b1, e(3, 17, 0, 1, 1));
        add_body("resync", "8-9", 3, 17);
        add("resync", 8'h0A, 1'b1, e(8, 9, 1, 0, 1));
        add_window("resync", 8, 9);
        add_body("hold_drop", "#4-6", 8, 9);
        add("hold_drop", 8'h0A, 1'b1, e(4, 6, 1, 0, 1));
        add("hold_drop", "#", 1'b1, e(4, 6, 1, 0, 1));
        add("hold_drop", "1", 1'b1, e(4, 6, 1, 0, 1));
        add("hold_drop", "-", 1'b1, e(4, 6, 1, 0, 1));
        add("hold_drop", "2", 1'b1, e(4, 6, 0, 0, 0));
        add("hold_drop", 8'h0A, 1'b1, e(4, 6, 0, 0, 0));
        add_body("max_node", "#29-0", 4, 6);
        add("max_node", 8'h0A, 1'b1, e(29, 0, 1, 0, 1));
        add_window("max_node", 29, 0);
        add_body("dash_cnt0", "#", 29, 0);
        add("dash_cnt0", "-", 1'b1, e(29, 0, 0, 1, 0));
        add_body("lf_cnt0", "#2-", 29, 0);
        add("lf_cnt0", 8'h0A, 1'b1, e(29, 0, 0, 1, 0));
        add_body("range_ep", "#2-30", 29, 0);
        add("range_ep", 8'h0A, 1'b1, e(29, 0, 0, 1, 0));
        add_body("sp_eq_ep", "#7-7", 29, 0);
        add("sp_eq_ep", 8'h0A, 1'b1, e(7, 7, 1, 0, 1));
        add_window("sp_eq_ep", 7, 7);
        add_body("lead_zero", "#09-05", 7, 7);
        add("lead_zero", 8'h0A, 1'b1, e(9, 5, 1, 0, 1));
        add_window("lead_zero", 9, 5);

        repeat (2) @(posedge adc_sck);
        #1 check("reset", e(0, 0, 0, 0, 0));
        @(negedge adc_sck);
        reset = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].data, vq[i].valid);
            check($sformatf("%s[%0d]", vq[i].tag, i), vq[i].exp);
        end

        // Reset in the middle of a frame.
        send("#1");
        @(negedge adc_sck);
        reset = 1'b1;
        bus.rx_valid = 1'b0;
        @(posedge adc_sck);
        #1 check("rst_mid", e(0, 0, 0, 0, 0));
        @(negedge adc_sck);
        reset = 1'b0;
        step(8'h00, 1'b0);
        check("rst_mid_idle", e(0, 0, 0, 0, 0));

        // Reset during HOLD drops cpu_reset at that edge.
        send("#3-4");
        step(8'h0A, 1'b1);
        check("pre_rst_hold", e(3, 4, 1, 0, 1));
        @(negedge adc_sck);
        reset = 1'b1;
        bus.rx_valid = 1'b0;
        @(posedge adc_sck);
        #1 check("rst_hold", e(0, 0, 0, 0, 0));
        @(negedge adc_sck);
        reset = 1'b0;
        send("#5-6");
        step(8'h0A, 1'b1);
        check("after_rst", e(5, 6, 1, 0, 1));
        repeat (4) step(8'h00, 1'b0);
        check("after_rst_end", e(5, 6, 0, 0, 0));

`ifdef CMD_TIMEOUT_EN
        send("#1-");
        repeat (19) step(8'h00, 1'b0);
        check("gap_19", e(5, 6, 0, 0, 1));
        step(8'h00, 1'b0);
        check("timeout", e(5, 6, 0, 1, 0));
        step(8'h00, 1'b0);
        check("timeout_end", e(5, 6, 0, 0, 0));
`else
        send("#1-");
        repeat (30) step(8'h00, 1'b0);
        check("no_timeout", e(5, 6, 0, 0, 1));
        send("2");
        step(8'h0A, 1'b1);
        check("late_finish", e(1, 2, 1, 0, 1));
        repeat (4) step(8'h00, 1'b0);
        check("late_finish_end", e(1, 2, 0, 0, 0));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
